// File: rtl/nn_pkg.sv
// Shared definitions for the on-chip MLP datapath: default widths,
// the pass-sequencer state type, and a saturating adder at accumulator width.
package nn_pkg;

  localparam int HID_W = 10;  // hidden activation width, unsigned
  localparam int W_W   = 8;   // weight width, signed
  localparam int ACC_W = 23;  // accumulator / result width, signed

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Signed add of two ACC_W-bit values, clamped to the representable range.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational multiply-accumulate step: unsigned activation times signed
// weight, added to a signed accumulator and clamped to the accumulator range.
// The add is done wide enough to hold both operands, so it also works when
// the accumulator is narrower than the product.
module mac_sat #(
  parameter int HID_W = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 23
) (
  input  logic [HID_W-1:0] hidden_val_i,
  input  logic [W_W-1:0]   w_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] sum_o
);

  localparam int PW = HID_W + W_W + 1;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [PW-1:0] hid_ext_s;
  logic signed [PW-1:0] w_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [SW-1:0] sum_s;

  // Product, wide signed sum, and clamp to the accumulator range
  always_comb begin
    hid_ext_s = {{(W_W+1){1'b0}}, hidden_val_i};
    w_ext_s   = {{(HID_W+1){w_i[W_W-1]}}, w_i};
    prod_s    = hid_ext_s * w_ext_s;
    sum_s     = {{(SW-ACC_W){acc_i[ACC_W-1]}}, acc_i}
              + {{(SW-PW){prod_s[PW-1]}}, prod_s};
    if (sum_s > MAX_V) begin
      sum_o = MAX_V[ACC_W-1:0];
    end else if (sum_s < MIN_V) begin
      sum_o = MIN_V[ACC_W-1:0];
    end else begin
      sum_o = sum_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/output_forward_mac.sv
// Output-neuron forward pass: walks idx_o over the hidden layer, accumulating
// hidden*weight with saturation, then presents final_o with valid_o until the
// backprop stage acknowledges it.
// Build option: define OUTPUT_RELU_EN to clamp a negative final sum to zero
// before it reaches final_o (the running accumulator is not clamped).
module output_forward_mac #(
  parameter int N_HIDDEN = 4,
  parameter int HID_W    = nn_pkg::HID_W,
  parameter int W_W      = nn_pkg::W_W,
  parameter int ACC_W    = nn_pkg::ACC_W,
  parameter int IDX_W    = $clog2(N_HIDDEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [HID_W-1:0] hidden_val_i,
  input  logic [W_W-1:0]   w_i,
  input  logic             ack_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [ACC_W-1:0] final_o,
  output logic             valid_o,
  output logic             busy_o
);

  import nn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  state_e           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [ACC_W-1:0] final_r, final_s;
  logic [ACC_W-1:0] sum_s, post_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;

  mac_sat #(
    .HID_W (HID_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac_sat (
    .hidden_val_i (hidden_val_i),
    .w_i          (w_i),
    .acc_i        (acc_r),
    .sum_o        (sum_s)
  );

  // Output activation applied to the last saturated sum of a pass
  always_comb begin
`ifdef OUTPUT_RELU_EN
    if (sum_s[ACC_W-1]) begin
      post_s = {ACC_W{1'b0}};
    end else begin
      post_s = sum_s;
    end
`else
    post_s = sum_s;
`endif
  end

  // Next-state and next-output logic; clear_i overrides every state
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    idx_s   = idx_r;
    final_s = final_r;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    if (clear_i) begin
      state_s = IDLE;
      acc_s   = {ACC_W{1'b0}};
      idx_s   = {IDX_W{1'b0}};
      final_s = {ACC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_s = ACCUM;
            acc_s   = {ACC_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        ACCUM: begin
          acc_s = sum_s;
          if (idx_r == LAST_IDX) begin
            final_s = post_s;
            idx_s   = {IDX_W{1'b0}};
            state_s = DONE;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = ACCUM;
          end
        end
        DONE: begin
          if (ack_i) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
          acc_s   = {ACC_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          final_s = {ACC_W{1'b0}};
        end
      endcase
    end
    valid_s = (state_s == DONE);
    busy_s  = (state_s == ACCUM);
  end

  // State and registered outputs, asynchronously cleared by rst_i
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      final_r <= {ACC_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      final_r <= final_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign idx_o   = idx_r;
  assign final_o = final_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;

endmodule
